// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO of {pc, instr} pairs between fetch and decode.
// Optional macro FQ_BYPASS_EN lets an entry flow straight through to decode when the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  input  logic [15:0]              if_pc,
  input  logic [15:0]              if_instr,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [15:0]              id_pc,
  output logic [15:0]              id_instr,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halt_locked
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds its payload stable while valid && !ready, and ready never
  // depends combinationally on the same interface's valid.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          halt_q, halt_d;

  logic full, empty, bypass, push, pop, direct, wr_en, rd_adv, is_hlt;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    if_ready = !full && !halt_q && !flush;
`ifdef FQ_BYPASS_EN
    bypass   = empty && if_valid && if_ready;
`else
    bypass   = 1'b0;
`endif
    id_valid = !empty || bypass;
    push     = if_valid && if_ready;
    pop      = id_valid && id_ready;
    // A bypassed entry consumed in the same cycle never touches storage.
    direct   = bypass && id_ready;
    wr_en    = push && !direct;
    rd_adv   = pop && !direct;
    is_hlt   = (if_instr[15:12] == 4'hF);
  end

  always_comb begin
    id_pc    = 16'h0000;
    id_instr = 16'h0000;
    if (!empty) begin
      id_pc    = mem_q[rd_ptr_q][31:16];
      id_instr = mem_q[rd_ptr_q][15:0];
    end else if (bypass) begin
      id_pc    = if_pc;
      id_instr = if_instr;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    halt_d   = halt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      halt_d   = 1'b0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(wr_en) - CW'(rd_adv);
      if (push && is_hlt) halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      halt_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      halt_q   <= halt_d;
    end
  end

  // Storage needs no reset: empty slots are never presented.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_en) mem_q[wr_ptr_q] <= {if_pc, if_instr};
  end

  assign count       = count_q;
  assign halt_locked = halt_q;

endmodule
